// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared parameters and state encoding for the lock operator
package lock_pkg;
   localparam int LVL_W   = 4;
   localparam int TIMEOUT = 64;
   localparam int TMR_W   = 7;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FILL_A  = 4'd1,
      OPEN_A  = 4'd2,
      ENTER   = 4'd3,
      CLOSE_A = 4'd4,
      MATCH_D = 4'd5,
      OPEN_D  = 4'd6,
      EXIT    = 4'd7,
      CLOSE_D = 4'd8,
      DONE    = 4'd9,
      ERROR   = 4'd10
   } state_t;
endpackage

// File: rtl/lock_wait_timer.sv
// rtl/lock_wait_timer.sv - per-state wait counter with expiry and first-cycle flags
module lock_wait_timer #(
   parameter int TMR_W   = 7,
   parameter int TIMEOUT = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired,
   output logic first
);
   logic [TMR_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   assign expired = (count == TMR_W'(TIMEOUT - 1));
   // A count of zero marks the first cycle spent in the current state.
   assign first   = (count == '0);
endmodule

// File: rtl/lock_operator.sv
// rtl/lock_operator.sv - sequences one boat transit through the canal lock
module lock_operator #(
   parameter int LVL_W   = lock_pkg::LVL_W,
   parameter int TIMEOUT = lock_pkg::TIMEOUT,
   parameter int TMR_W   = lock_pkg::TMR_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             boatReq,
   input  logic [LVL_W-1:0] arrivOutsideLvl,
   input  logic [LVL_W-1:0] deptOutsideLvl,
   input  logic [LVL_W-1:0] insideWaterLvl,
   input  logic             arrivGate,
   input  logic             deptGate,
   input  logic             poundOccupied,
   output logic             incr,
   output logic             decr,
   output logic             gateCtrl,
   output logic             fiveMinTillArrival,
   output logic             busy,
   output logic             done,
   output logic             error
);
   import lock_pkg::*;

   state_t           state, state_nx, succ;
   logic [LVL_W-1:0] tgt_a, tgt_d;
   logic             waiting, exit_ok, expired, first;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         tgt_a <= '0;
         tgt_d <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && boatReq) begin
            tgt_a <= arrivOutsideLvl;
            tgt_d <= deptOutsideLvl;
         end
      end
   end

   always_comb begin
      state_nx           = state;
      succ               = IDLE;
      waiting            = 1'b0;
      exit_ok            = 1'b0;
      incr               = 1'b0;
      decr               = 1'b0;
      gateCtrl           = 1'b0;
      fiveMinTillArrival = 1'b0;
      busy               = 1'b1;
      done               = 1'b0;
      error              = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (boatReq) state_nx = FILL_A;
         end
         FILL_A: begin
            fiveMinTillArrival = 1'b1;
            incr    = insideWaterLvl < tgt_a;
            decr    = insideWaterLvl > tgt_a;
            exit_ok = insideWaterLvl == tgt_a;
            waiting = 1'b1;
            succ    = OPEN_A;
         end
         OPEN_A: begin
            fiveMinTillArrival = 1'b1;
            gateCtrl = first;
            exit_ok  = arrivGate;
            waiting  = 1'b1;
            succ     = ENTER;
         end
         ENTER: begin
            fiveMinTillArrival = 1'b1;
            exit_ok = poundOccupied;
            waiting = 1'b1;
            succ    = CLOSE_A;
         end
         CLOSE_A: begin
            gateCtrl = first;
            exit_ok  = !arrivGate;
            waiting  = 1'b1;
            succ     = MATCH_D;
         end
         MATCH_D: begin
            incr    = insideWaterLvl < tgt_d;
            decr    = insideWaterLvl > tgt_d;
            exit_ok = insideWaterLvl == tgt_d;
            waiting = 1'b1;
            succ    = OPEN_D;
         end
         OPEN_D: begin
            gateCtrl = first;
            exit_ok  = deptGate;
            waiting  = 1'b1;
            succ     = EXIT;
         end
         EXIT: begin
            exit_ok = !poundOccupied;
            waiting = 1'b1;
            succ    = CLOSE_D;
         end
         CLOSE_D: begin
            gateCtrl = first;
            exit_ok  = !deptGate;
            waiting  = 1'b1;
            succ     = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         ERROR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
         default: begin
            busy     = 1'b0;
            state_nx = IDLE;
         end
      endcase
      // Exit wins over timeout when both happen in the same cycle.
      if (waiting) begin
         if (exit_ok)
            state_nx = succ;
         else if (expired)
            state_nx = ERROR;
      end
   end

   lock_wait_timer #(
      .TMR_W   (TMR_W),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (state_nx != state),
      .enable  (busy),
      .expired (expired),
      .first   (first)
   );
endmodule

// File: tb/tb_lock_operator.sv
// tb/tb_lock_operator.sv - randomized self-checking bench with lock and operator models
module tb_lock_operator;
   localparam int TO = lock_pkg::TIMEOUT;

   logic       clock = 1'b0;
   logic       reset = 1'b1, boatReq = 1'b0;
   logic [3:0] arrivOutsideLvl = '0, deptOutsideLvl = '0, insideWaterLvl = '0;
   logic       arrivGate = 1'b0, deptGate = 1'b0, poundOccupied = 1'b0;
   logic       incr, decr, gateCtrl, fiveMinTillArrival, busy, done, error;

   always #5 clock = ~clock;

   lock_operator dut (
      .clock(clock), .reset(reset), .boatReq(boatReq),
      .arrivOutsideLvl(arrivOutsideLvl), .deptOutsideLvl(deptOutsideLvl),
      .insideWaterLvl(insideWaterLvl), .arrivGate(arrivGate), .deptGate(deptGate),
      .poundOccupied(poundOccupied), .incr(incr), .decr(decr), .gateCtrl(gateCtrl),
      .fiveMinTillArrival(fiveMinTillArrival), .busy(busy), .done(done), .error(error)
   );

   int checks = 0, errors = 0;
   // Operator model: step 0 idle, 1..8 the transit steps in order, 9 done, 10 error.
   int m_s = 0, m_age = 0;
   logic [3:0] m_ta = '0, m_td = '0;
   // Lock model: gate pulses 1-2 move the arrival gate, 3-4 the departure gate.
   int gp = 0, pend = 0, pend_sel = 0;
   bit stuck = 0;
   int cyc = 0, n_incr = 0, n_decr = 0, n_gate = 0, n_done = 0;
   int last_gate_cyc = 0, first_err_cyc = 0;
   logic prev_gate = 1'b0, prev_err = 1'b0;
   logic [6:0] s_vec = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_exit(input int s);
      case (s)
         1: return insideWaterLvl == m_ta;
         2: return arrivGate;
         3: return poundOccupied;
         4: return !arrivGate;
         5: return insideWaterLvl == m_td;
         6: return deptGate;
         7: return !poundOccupied;
         8: return !deptGate;
         default: return 1'b0;
      endcase
   endfunction

   task automatic cycle();
      logic [6:0] e;
      logic [3:0] lvl_n;
      logic ag_n, dg_n, occ_n;
      @(negedge clock);
      cyc++;
      e[6] = (m_s == 1 && insideWaterLvl < m_ta) || (m_s == 5 && insideWaterLvl < m_td);
      e[5] = (m_s == 1 && insideWaterLvl > m_ta) || (m_s == 5 && insideWaterLvl > m_td);
      e[4] = (m_s == 2 || m_s == 4 || m_s == 6 || m_s == 8) && m_age == 0;
      e[3] = m_s >= 1 && m_s <= 3;
      e[2] = m_s >= 1 && m_s <= 9;
      e[1] = m_s == 9;
      e[0] = m_s == 10;
      s_vec = {incr, decr, gateCtrl, fiveMinTillArrival, busy, done, error};
      chk("outputs", 32'(s_vec), 32'(e));
      chk("incr_and_decr", 32'(incr & decr), 0);
      chk("gate_back_to_back", 32'(prev_gate & gateCtrl), 0);
      n_incr += int'(incr);
      n_decr += int'(decr);
      n_gate += int'(gateCtrl);
      n_done += int'(done);
      if (gateCtrl) last_gate_cyc = cyc;
      if (error && !prev_err) first_err_cyc = cyc;
      prev_gate = gateCtrl;
      prev_err  = error;

      if (reset) begin
         m_s = 0; m_age = 0;
      end else if (m_s == 0) begin
         if (boatReq) begin
            m_ta = arrivOutsideLvl; m_td = deptOutsideLvl; m_s = 1; m_age = 0;
         end
      end else if (m_s == 9) begin
         m_s = 0;
      end else if (m_s != 10) begin
         if (m_exit(m_s)) begin
            m_s++; m_age = 0;
         end else if (m_age == TO - 1) m_s = 10;
         else m_age++;
      end

      lvl_n = insideWaterLvl + 4'(incr) - 4'(decr);
      ag_n = arrivGate; dg_n = deptGate; occ_n = poundOccupied;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            if (pend_sel == 0) ag_n = !ag_n;
            else dg_n = !dg_n;
         end
      end
      if (gateCtrl) begin
         pend_sel = (gp < 2) ? 0 : 1;
         gp++;
         if (!(stuck && pend_sel == 0)) pend = 1 + $urandom_range(0, 2);
      end
      if (arrivGate && fiveMinTillArrival && !poundOccupied && $urandom_range(0, 1) == 1) occ_n = 1'b1;
      if (deptGate && poundOccupied && !fiveMinTillArrival && $urandom_range(0, 1) == 1) occ_n = 1'b0;
      if (done) gp = 0;
      if (reset) begin
         ag_n = 1'b0; dg_n = 1'b0; occ_n = 1'b0; gp = 0; pend = 0;
      end
      @(posedge clock);
      #1;
      insideWaterLvl = lvl_n;
      arrivGate = ag_n;
      deptGate = dg_n;
      poundOccupied = occ_n;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      int k = 0;
      do begin
         cycle();
         k++;
      end while (!s_vec[1] && k < budget);
      chk("done_reached", 32'(s_vec[1]), 1);
   endtask

   task automatic start(input logic [3:0] a, input logic [3:0] d, input logic [3:0] in_lvl);
      arrivOutsideLvl = a; deptOutsideLvl = d; insideWaterLvl = in_lvl; boatReq = 1'b1;
      cycle();
      boatReq = 1'b0;
   endtask

   initial begin
      int gi, ii, di, dn, k;
      // 1: reset state, then a transit whose arrival level already matches
      do_reset();
      cycle();
      chk("reset_outputs", 32'(s_vec), 0);
      gi = n_gate; ii = n_incr;
      start(4'd0, 4'd1, 4'd0);
      cycle();
      chk("fill_a_five", 32'(s_vec[3]), 1);
      chk("fill_a_no_cmd", 32'(s_vec[6:5]), 0);
      cycle();
      chk("open_a_pulse", 32'(s_vec[4]), 1);
      run_to_done(400);
      chk("t1_gate_pulses", n_gate - gi, 4);
      chk("t1_incr_cycles", n_incr - ii, 1);

      // 2: full transit 5 -> 3 -> 9
      gi = n_gate; ii = n_incr; di = n_decr; dn = n_done;
      start(4'd3, 4'd9, 4'd5);
      run_to_done(400);
      chk("t2_decr_cycles", n_decr - di, 2);
      chk("t2_gate_pulses", n_gate - gi, 4);
      chk("t2_incr_cycles", n_incr - ii, 6);
      chk("t2_done_pulses", n_done - dn, 1);
      cycle();
      chk("t2_back_idle", 32'(s_vec[2]), 0);

      // 3: arrival gate never opens
      do_reset();
      stuck = 1;
      start(4'd7, 4'd2, 4'd7);
      k = 0;
      do begin cycle(); k++; end while (!s_vec[0] && k < 200);
      chk("t3_error_seen", 32'(s_vec[0]), 1);
      chk("t3_error_latency", first_err_cyc - last_gate_cyc, TO);
      for (int i = 0; i < 20; i++) begin
         boatReq = 1'(i % 2);
         cycle();
      end
      boatReq = 1'b0;
      chk("t3_error_sticky", 32'(s_vec), 1);
      stuck = 0;
      do_reset();

      // 4: boatReq held across a transit, dropped in first IDLE cycle
      dn = n_done;
      arrivOutsideLvl = 4'($urandom); deptOutsideLvl = 4'($urandom); insideWaterLvl = 4'($urandom);
      boatReq = 1'b1;
      run_to_done(600);
      boatReq = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("t4_one_transit", n_done - dn, 1);
      chk("t4_stays_idle", 32'(s_vec[2]), 0);
      // held into the first IDLE cycle: a second transit starts
      boatReq = 1'b1;
      run_to_done(600);
      cycle();
      boatReq = 1'b0;
      cycle();
      chk("t4_restart", 32'(s_vec[2]), 1);
      run_to_done(600);

      // 5: reset during MATCH_D while raising
      cycle();
      start(4'd0, 4'd15, 4'd0);
      k = 0;
      do begin cycle(); k++; end while (!(s_vec[6] && !s_vec[3]) && k < 400);
      chk("t5_in_match_d", 32'(s_vec[6]), 1);
      reset = 1'b1;
      cycle();
      chk("t5_incr_before", 32'(s_vec[6]), 1);
      reset = 1'b0;
      cycle();
      chk("t5_incr_after", 32'(s_vec[6]), 0);
      chk("t5_busy_after", 32'(s_vec[2]), 0);

      // randomized traffic, including requests while busy and in DONE
      for (int i = 0; i < 1500; i++) begin
         boatReq = ($urandom_range(0, 3) == 0);
         arrivOutsideLvl = 4'($urandom);
         deptOutsideLvl = 4'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
